// File: rtl/btn_press_detect_if.sv
`default_nettype none
// ============================================================================
// Module   : btn_press_detect_if
// Brief    : Button inputs and press-event outputs of btn_press_detect.
// Revision : 1.0
// ============================================================================
interface btn_press_detect_if #(
  parameter int N_BTN  = 4,
  parameter int CODE_W = (N_BTN > 1) ? $clog2(N_BTN) : 1
);
  logic [N_BTN-1:0]  btn;
  logic [N_BTN-1:0]  held;
  logic [N_BTN-1:0]  press_pulse;
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              multi;
  logic [N_BTN-1:0]  long_pulse;

  // master drives the raw buttons and consumes events; slave is the detector
  modport master (
    output btn,
    input  held, press_pulse, key_valid, key_code, multi, long_pulse
  );

  modport slave (
    input  btn,
    output held, press_pulse, key_valid, key_code, multi, long_pulse
  );
endinterface
`default_nettype wire

// File: rtl/btn_press_detect.sv
`default_nettype none
// ============================================================================
// Module   : btn_press_detect
// Brief    : N-channel sync + debounce + one-cycle press/long-press events.
//            Optional long-press counters enabled by LONG_PRESS_EN.
// Revision : 1.0
// ============================================================================
module btn_press_detect #(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = 20,
  parameter int LONG_CYC     = 1000,
  parameter int CODE_W       = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  btn_press_detect_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [N_BTN-1:0]  held_q;
  logic [N_BTN-1:0]  held_d;
  logic [N_BTN-1:0]  long_w;

  logic [N_BTN-1:0]  press_d;
  logic [N_BTN-1:0]  press_q;
  logic              key_valid_d;
  logic              key_valid_q;
  logic [CODE_W-1:0] key_code_d;
  logic [CODE_W-1:0] key_code_q;
  logic              multi_d;
  logic              multi_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The level only flips after DEBOUNCE_CYC consecutive mismatching samples
    always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      if (sync2_q == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= bus.btn[i];
        sync2_q <= sync1_q;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
      end
    end

    assign held_q[i] = deb_q;
    assign held_d[i] = deb_d;

`ifdef LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYC - 1);

    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              lp_q;
    logic              lp_d;

    // Saturation at HOLD_MAX is what limits the event to once per press
    always_comb begin
      hold_d = '0;
      lp_d   = 1'b0;
      if (deb_q) begin
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        lp_d   = (hold_q == HOLD_PRE);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold_q <= '0;
        lp_q   <= 1'b0;
      end else begin
        hold_q <= hold_d;
        lp_q   <= lp_d;
      end
    end

    assign long_w[i] = lp_q;
`else
    assign long_w[i] = 1'b0;
`endif
  end

  assign press_d = held_d & ~held_q;

  always_comb begin
    key_code_d = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      if (press_d[k]) begin
        key_code_d = CODE_W'(k);
      end
    end
  end

  always_comb begin
    logic seen;
    seen    = 1'b0;
    multi_d = 1'b0;
    for (int k = 0; k < N_BTN; k++) begin
      if (press_d[k]) begin
        if (seen) begin
          multi_d = 1'b1;
        end
        seen = 1'b1;
      end
    end
  end

  assign key_valid_d = |press_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      press_q     <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      multi_q     <= 1'b0;
    end else begin
      press_q     <= press_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      multi_q     <= multi_d;
    end
  end

  assign bus.held        = held_q;
  assign bus.press_pulse = press_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_code    = key_code_q;
  assign bus.multi       = multi_q;
  assign bus.long_pulse  = long_w;

endmodule
`default_nettype wire

// File: doc/btn_press_detect.md
Name: btn_press_detect

Overview:
Parametrised N-channel push-button front end. Synchronises each raw button input, debounces it with a configurable stable-time counter, and emits one-cycle press pulses. It also emits an encoded key index for the lowest-numbered press in that cycle, plus a flag when several presses land in the same cycle. Sits between board push-buttons and the lab control FSMs, which consume single-cycle press events.

Parameters:
N_BTN, 4, number of button channels (≥1)
DEBOUNCE_CYC, 20, consecutive stable cycles required before the debounced level changes (≥1)
LONG_CYC, 1000, cycles the debounced level must stay high before a long-press pulse (used only with LONG_PRESS_EN, ≥1)
CODE_W, $clog2(N_BTN) with a minimum of 1, width of key_code

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
btn  in  N_BTN  raw asynchronous button levels, 1 = pressed
held  out  N_BTN  debounced button levels
press_pulse  out  N_BTN  per-channel one-cycle press event
key_valid  out  1  one-cycle: at least one press_pulse bit set
key_code  out  CODE_W  index of lowest set press_pulse bit; valid with key_valid
multi  out  1  one-cycle: two or more press_pulse bits set together
long_pulse  out  N_BTN  per-channel one-cycle long-press event (tied 0 without LONG_PRESS_EN)

Behaviour:
- Reset: while rst=0, all registers clear asynchronously. This includes the sync flops, counters, held, press_pulse, key_valid, key_code, multi and long_pulse. All outputs are 0 during and just after reset.
- Synchroniser: 2 flops per channel, s1<=btn, s2<=s1. No combinational path from btn to any output.
- Debounce, per channel, each edge:
  - s2==held: cnt<=0.
  - s2!=held and cnt==DEBOUNCE_CYC-1: held<=s2, cnt<=0.
  - s2!=held otherwise: cnt<=cnt+1.
  - cnt width is $clog2(DEBOUNCE_CYC)+1; it never wraps.
- Glitch rejection: any mismatch shorter than DEBOUNCE_CYC consecutive cycles resets cnt and leaves held unchanged.
- Latency: btn rises and is stable before edge 1 → held and press_pulse go high at edge DEBOUNCE_CYC+2.
- press_pulse[i]: registered, set on exactly the edge where held[i] goes 0→1, cleared next edge. Release (1→0) produces no pulse. One pulse per debounced press regardless of hold time.
- key_valid / key_code / multi: registered in the same edge as press_pulse, computed from the next-state pulse vector.
  - key_code = lowest index set; 0 when key_valid=0.
  - multi = popcount ≥ 2.
- Simultaneous presses: all corresponding press_pulse bits assert together; key_code reports the lowest index; multi=1.
- Button held through reset release: held starts 0, so a press_pulse is produced DEBOUNCE_CYC+2 cycles after rst deasserts.
- Reset mid-debounce: the count is discarded; debounce restarts from 0 after release.

Optional Feature:
LONG_PRESS_EN
- Defined: a per-channel hold counter runs while held[i]=1 and saturates at LONG_CYC. long_pulse[i] is a one-cycle pulse on the edge the counter reaches LONG_CYC, at most once per press. Counter clears when held[i]=0 or on reset.
- Undefined: hold counters are not built and long_pulse is constant 0.

Test Plan:
- N_BTN=4, DEBOUNCE_CYC=4; reset, then btn=4'b0100 stable from edge 1 → held[2]=1 and press_pulse=4'b0100 at edge 6 only; key_valid=1, key_code=2, multi=0 for that one cycle.
- Glitch: btn[0] high for 3 cycles, then low → held, press_pulse and key_valid stay 0 throughout.
- btn=4'b1010 applied in the same cycle → press_pulse=4'b1010 at edge 6; key_code=1, multi=1; release produces no pulse, and held returns to 0 after 4 stable-low cycles.
- Bounce: btn[3] toggling every 2 cycles for 20 cycles, then stable high → exactly one press_pulse[3], 6 edges after the last toggle.
- Reset asserted at cnt=2 with btn[1] held, released later with btn[1] still high → all outputs 0 during reset; one press_pulse[1] at 6 edges after rst deasserts.
- LONG_PRESS_EN, LONG_CYC=10: btn[0] held 30 cycles → exactly one long_pulse[0], 10 edges after held[0] rises. Without the macro, long_pulse stays 0.
